// File: rtl/mem_req_buffer_if.sv
// mem_req_buffer_if
//   Bundles the three handshakes around mem_req_buffer:
//     req_*  core -> buffer request channel (valid/ready)
//     mem_*  buffer -> RAM request strobe plus RAM read data/exception return
//     rsp_*  buffer -> core response channel (valid/ready)
//   slave  : the buffer side
//   master : the core/RAM side (testbench or surrounding logic)
interface mem_req_buffer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_mask;
  logic [63:0] req_addr;
  logic [63:0] req_data;

  logic        mem_enable;
  logic [1:0]  mem_op;
  logic [7:0]  mem_mask;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic [63:0] mem_resp;
  logic        mem_exc;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_exc;

  modport slave (
    input  req_valid, req_op, req_mask, req_addr, req_data,
    input  mem_resp, mem_exc, rsp_ready,
    output req_ready, mem_enable, mem_op, mem_mask, mem_addr, mem_data,
    output rsp_valid, rsp_data, rsp_exc
  );

  modport master (
    output req_valid, req_op, req_mask, req_addr, req_data,
    output mem_resp, mem_exc, rsp_ready,
    input  req_ready, mem_enable, mem_op, mem_mask, mem_addr, mem_data,
    input  rsp_valid, rsp_data, rsp_exc
  );
endinterface

// File: rtl/mem_req_buffer.sv
// mem_req_buffer
//   Decoupling stage between the core data-memory request port and the RAM.
//   Requests are queued in a small FIFO and issued one per cycle on registered
//   mem_* outputs. Load/amo read data returns one cycle after mem_enable and is
//   queued in a response FIFO toward the core. Load/amo issue is throttled by
//   response-slot credits so a captured response always has room.
//
// Ports
//   CLK    rising-edge clock
//   RESET  synchronous active-low reset
//   bus    mem_req_buffer_if.slave (req_*, mem_*, rsp_* channels)
//   stat_issued / stat_credit_stall / stat_full
//          32-bit saturating counters, present only when MEM_REQ_BUFFER_STATS_EN
//          is defined
//
// Optional feature macro: MEM_REQ_BUFFER_STATS_EN
module mem_req_buffer #(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input logic             CLK,
  input logic             RESET,
  mem_req_buffer_if.slave bus
`ifdef MEM_REQ_BUFFER_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_credit_stall,
  output logic [31:0]     stat_full
`endif
);

  localparam int RQ_AW = $clog2(REQ_DEPTH);
  localparam int RS_AW = $clog2(RSP_DEPTH);
  localparam int CR_W  = $clog2(RSP_DEPTH) + 1;
  localparam logic [RQ_AW:0]  RQ_FULL = REQ_DEPTH[RQ_AW:0];
  localparam logic [CR_W-1:0] CR_MAX  = RSP_DEPTH[CR_W-1:0];

  logic [1:0]  rq_op   [REQ_DEPTH];
  logic [7:0]  rq_mask [REQ_DEPTH];
  logic [63:0] rq_addr [REQ_DEPTH];
  logic [63:0] rq_data [REQ_DEPTH];
  logic [RQ_AW-1:0] rq_wr, rq_rd;
  logic [RQ_AW:0]   rq_cnt;

  logic [64:0]      rs_mem [RSP_DEPTH];
  logic [RS_AW-1:0] rs_wr, rs_rd;
  logic [RS_AW:0]   rs_cnt;
  logic [64:0]      rs_head;

  logic [CR_W-1:0] credits;
  logic            in_flight;

  logic head_ld, issue, push_req, pop_rsp;

  // Ops 01 (load) and 11 (amo) both return data; bit 0 identifies them.
  assign head_ld  = rq_op[rq_rd][0];
  assign issue    = (rq_cnt != '0) && (!head_ld || (credits != '0));

  assign bus.req_ready = RESET && (rq_cnt != RQ_FULL);
  // Nops complete the handshake but are never queued.
  assign push_req = bus.req_valid && bus.req_ready && (bus.req_op != 2'b00);

  assign bus.rsp_valid = (rs_cnt != '0);
  assign pop_rsp       = bus.rsp_valid && bus.rsp_ready;
  // Gate the head so an empty FIFO presents zeros rather than stale data.
  assign rs_head       = bus.rsp_valid ? rs_mem[rs_rd] : '0;
  assign bus.rsp_exc   = rs_head[64];
  assign bus.rsp_data  = rs_head[63:0];

  // Storage arrays need no reset; pointers and counts define validity.
  always_ff @(posedge CLK) begin
    if (push_req) begin
      rq_op[rq_wr]   <= bus.req_op;
      rq_mask[rq_wr] <= bus.req_mask;
      rq_addr[rq_wr] <= bus.req_addr;
      rq_data[rq_wr] <= bus.req_data;
    end
    if (in_flight) begin
      rs_mem[rs_wr] <= {bus.mem_exc, bus.mem_resp};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rq_wr          <= '0;
      rq_rd          <= '0;
      rq_cnt         <= '0;
      rs_wr          <= '0;
      rs_rd          <= '0;
      rs_cnt         <= '0;
      credits        <= CR_MAX;
      in_flight      <= 1'b0;
      bus.mem_enable <= 1'b0;
      bus.mem_op     <= '0;
      bus.mem_mask   <= '0;
      bus.mem_addr   <= '0;
      bus.mem_data   <= '0;
    end else begin
      if (push_req) rq_wr <= rq_wr + RQ_AW'(1);
      if (issue)    rq_rd <= rq_rd + RQ_AW'(1);
      case ({push_req, issue})
        2'b10:   rq_cnt <= rq_cnt + (RQ_AW+1)'(1);
        2'b01:   rq_cnt <= rq_cnt - (RQ_AW+1)'(1);
        default: ;
      endcase

      bus.mem_enable <= issue;
      if (issue) begin
        bus.mem_op   <= rq_op[rq_rd];
        bus.mem_mask <= rq_mask[rq_rd];
        bus.mem_addr <= rq_addr[rq_rd];
        bus.mem_data <= rq_data[rq_rd];
      end

      // RAM data is valid the cycle after the strobe; capture on the next edge.
      in_flight <= bus.mem_enable && bus.mem_op[0];

      if (in_flight) rs_wr <= rs_wr + RS_AW'(1);
      if (pop_rsp)   rs_rd <= rs_rd + RS_AW'(1);
      case ({in_flight, pop_rsp})
        2'b10:   rs_cnt <= rs_cnt + (RS_AW+1)'(1);
        2'b01:   rs_cnt <= rs_cnt - (RS_AW+1)'(1);
        default: ;
      endcase

      case ({issue && head_ld, pop_rsp})
        2'b10:   credits <= credits - CR_W'(1);
        2'b01:   credits <= credits + CR_W'(1);
        default: ;
      endcase
    end
  end

`ifdef MEM_REQ_BUFFER_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stat_issued       <= '0;
      stat_credit_stall <= '0;
      stat_full         <= '0;
    end else begin
      if (issue && (stat_issued != '1))
        stat_issued <= stat_issued + 32'd1;
      if ((rq_cnt != '0) && head_ld && (credits == '0) && (stat_credit_stall != '1))
        stat_credit_stall <= stat_credit_stall + 32'd1;
      if ((rq_cnt == RQ_FULL) && (stat_full != '1))
        stat_full <= stat_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_buffer.sv
module tb_mem_req_buffer;
  localparam int RQD = 4;
  localparam int RSD = 4;
  localparam logic [1:0] OP_NOP = 2'b00, OP_LD = 2'b01, OP_ST = 2'b10, OP_AMO = 2'b11;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  mem_req_buffer_if bus ();

`ifdef MEM_REQ_BUFFER_STATS_EN
  logic [31:0] stat_issued, stat_credit_stall, stat_full;
  mem_req_buffer #(.REQ_DEPTH(RQD), .RSP_DEPTH(RSD)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .stat_issued(stat_issued), .stat_credit_stall(stat_credit_stall), .stat_full(stat_full)
  );
`else
  mem_req_buffer #(.REQ_DEPTH(RQD), .RSP_DEPTH(RSD)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );
`endif

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  mask;
    logic [63:0] addr;
    logic [63:0] data;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic        exc;
    int          avail;
  } rsp_t;

  // Reference model: requests waiting to reach RAM, responses owed to the core.
  req_t req_q[$];
  rsp_t rsp_q[$];
  int   loads_out;            // load/amo issued whose response is not yet popped
  int   pulses, ld_pulses, pops;
  int   cyc_n;
  logic exp_issue;
  logic ram_pend;
  logic [63:0] ram_data;
  logic ram_exc;
  logic force_exc;
  logic saw_issue;
  int   ready_low;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ram();
    if (ram_pend) begin
      bus.mem_resp = ram_data;
      bus.mem_exc  = ram_exc;
    end else begin
      bus.mem_resp = {$urandom, $urandom};
      bus.mem_exc  = 1'($urandom);
    end
    ram_pend = 1'b0;
  endtask

  // One clock: check outputs after the edge, predict next issue, drive inputs.
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] mask,
                      input logic [63:0] addr, input logic [63:0] data,
                      input logic rr, output logic acc);
    req_t h;
    rsp_t r;
    logic rv;
    @(posedge CLK);
    #1;
    cyc_n++;
    drive_ram();
    saw_issue = 1'b0;

    chk("mem_enable", bus.mem_enable, exp_issue);
    if (bus.mem_enable === 1'b1 && req_q.size() > 0) begin
      saw_issue = 1'b1;
      pulses++;
      h = req_q.pop_front();
      chk("mem_op",   bus.mem_op,   h.op);
      chk("mem_mask", bus.mem_mask, h.mask);
      chk("mem_addr", bus.mem_addr, h.addr);
      chk("mem_data", bus.mem_data, h.data);
      if (h.op == OP_LD || h.op == OP_AMO) begin
        loads_out++;
        ld_pulses++;
        ram_pend = 1'b1;
        ram_data = {$urandom, $urandom};
        ram_exc  = force_exc;
        r.data   = ram_data;
        r.exc    = ram_exc;
        r.avail  = cyc_n + 2;
        rsp_q.push_back(r);
      end
    end

    chk("req_ready", bus.req_ready, req_q.size() < RQD);
    if (bus.req_ready !== 1'b1) ready_low++;
    rv = (rsp_q.size() > 0) && (rsp_q[0].avail <= cyc_n);
    chk("rsp_valid", bus.rsp_valid, rv);
    if (rv) begin
      chk("rsp_data", bus.rsp_data, rsp_q[0].data);
      chk("rsp_exc",  bus.rsp_exc,  rsp_q[0].exc);
    end

    // Next edge issues if work is queued and, for a load/amo head, a slot is free.
    exp_issue = (req_q.size() > 0) &&
                (!(req_q[0].op == OP_LD || req_q[0].op == OP_AMO) || loads_out < RSD);

    acc = v && (req_q.size() < RQD);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_mask  = mask;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.rsp_ready = rr;
    if (acc && op != OP_NOP) begin
      h.op = op; h.mask = mask; h.addr = addr; h.data = data;
      req_q.push_back(h);
    end
    if (rr && rv) begin
      void'(rsp_q.pop_front());
      loads_out--;
      pops++;
    end
  endtask

  task automatic idle(input int n, input logic rr);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, OP_NOP, 8'h00, 64'h0, 64'h0, rr, a);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] mask,
                      input logic [63:0] addr, input logic [63:0] data, input logic rr);
    logic a;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 40) begin
      step(1'b1, op, mask, addr, data, rr, a);
      tries++;
    end
    if (!a) chk("send_timeout", a, 1'b1);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LD;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc_n++;
      drive_ram();
      chk("rst_req_ready",  bus.req_ready,  1'b0);
      chk("rst_mem_enable", bus.mem_enable, 1'b0);
      chk("rst_mem_op",     bus.mem_op,     2'b00);
      chk("rst_mem_addr",   bus.mem_addr,   64'h0);
      chk("rst_rsp_valid",  bus.rsp_valid,  1'b0);
      chk("rst_rsp_data",   bus.rsp_data,   64'h0);
      chk("rst_rsp_exc",    bus.rsp_exc,    1'b0);
    end
    RESET = 1'b1;
    bus.req_valid = 1'b0;
    req_q.delete();
    rsp_q.delete();
    loads_out = 0;
    exp_issue = 1'b0;
  endtask

  int   base_p, base_l, base_pops, tries;
  logic empty;

  initial begin
    bus.req_valid = 1'b0; bus.req_op = OP_NOP; bus.req_mask = 8'h00;
    bus.req_addr = 64'h0; bus.req_data = 64'h0; bus.rsp_ready = 1'b0;
    bus.mem_resp = 64'h0; bus.mem_exc = 1'b0;
    loads_out = 0; pulses = 0; ld_pulses = 0; pops = 0; cyc_n = 0;
    exp_issue = 1'b0; ram_pend = 1'b0; ram_data = 64'h0; ram_exc = 1'b0;
    force_exc = 1'b0; saw_issue = 1'b0; ready_low = 0;

    // reset held three cycles with a request pending
    do_reset(3);
    idle(1, 1'b1);

    // single load
    base_pops = pops;
    send(OP_LD, 8'hFF, 64'h1000, 64'h0, 1'b1);
    idle(6, 1'b1);
    chk("single_load_pops", pops - base_pops, 1);

    // credit stall: eight loads with responses back-pressured
    base_l = ld_pulses; base_pops = pops; ready_low = 0;
    for (int i = 0; i < 8; i++) send(OP_LD, 8'hFF, 64'h2000 + 64'(i * 8), 64'h0, 1'b0);
    idle(6, 1'b0);
    chk("stall_pulses", ld_pulses - base_l, 4);
    chk("stall_ready_dropped", ready_low > 0, 1'b1);
    idle(20, 1'b1);
    chk("stall_all_issued", ld_pulses - base_l, 8);
    chk("stall_all_popped", pops - base_pops, 8);

    // store / nop / load / store
    base_p = pulses; base_pops = pops;
    send(OP_ST,  8'h0F, 64'h3000, 64'h1111_2222_3333_4444, 1'b1);
    send(OP_NOP, 8'hFF, 64'h3008, 64'h5555, 1'b1);
    send(OP_LD,  8'hFF, 64'h3010, 64'h0, 1'b1);
    send(OP_ST,  8'hF0, 64'h3018, 64'h6666_7777_8888_9999, 1'b1);
    idle(8, 1'b1);
    chk("mix_pulses", pulses - base_p, 3);
    chk("mix_pops", pops - base_pops, 1);

    // exception on one response only
    force_exc = 1'b1;
    send(OP_LD, 8'hFF, 64'h4000, 64'h0, 1'b1);
    force_exc = 1'b0;
    send(OP_AMO, 8'hFF, 64'h4008, 64'hABCD, 1'b1);
    idle(8, 1'b1);

    // reset the cycle after a load issues; its data must be dropped
    send(OP_LD, 8'hFF, 64'h5000, 64'h0, 1'b0);
    tries = 0;
    saw_issue = 1'b0;
    while (!saw_issue && tries < 10) begin
      idle(1, 1'b0);
      tries++;
    end
    chk("midflight_issue_seen", saw_issue, 1'b1);
    idle(1, 1'b0);
    do_reset(2);
    idle(6, 1'b1);
    base_l = ld_pulses;
    for (int i = 0; i < 4; i++) send(OP_LD, 8'hFF, 64'h6000 + 64'(i * 8), 64'h0, 1'b0);
    idle(3, 1'b0);
    chk("post_reset_credits", ld_pulses - base_l, 4);
    idle(12, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic a;
      force_exc = 1'($urandom);
      step(($urandom % 3) != 0, 2'($urandom), 8'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, ($urandom % 4) != 0, a);
    end

    // drain
    tries = 0;
    empty = 1'b0;
    while (!empty && tries < 100) begin
      idle(1, 1'b1);
      empty = (req_q.size() == 0) && (rsp_q.size() == 0) && !exp_issue;
      tries++;
    end
    chk("drain_complete", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
